regd_wb_arbiter: RTL and testbench
==================================

# regd_wb_arbiter

Arbitrates the single register-file write port between the execute stage's direct writeback and load-queue return data. Keeps a pending-load scoreboard and reports RAW/WAW hazards to the instruction decoder. Issues a stall to the decoder when load returns are starved. Sits between ex_stage, the load/store queue and the register file.

## Interface
- C_XLEN, 32, data width
- C_STARVE_MAX, 4, consecutive cycles an unacknowledged load return may wait before the decoder is stalled (1..15)

- clk_i  in  1  clock
- resetb_i  in  1  reset; asynchronous, active-low
- clk_en_i  in  1  global clock enable; when low, all state holds and lq_ack_o=0
- ex_regd_wr_i  in  1  EX writeback request; cannot be back-pressured
- ex_regd_addr_i  in  5  EX destination register
- ex_regd_data_i  in  C_XLEN  EX writeback data
- ex_lq_wr_i  in  1  a load is being pushed to the load queue this cycle
- ex_lq_regd_addr_i  in  5  destination of that load
- lq_dav_i  in  1  load return data valid
- lq_ack_o  out  1  load return accepted this cycle
- lq_regd_addr_i  in  5  load return destination
- lq_regd_data_i  in  C_XLEN  load return data
- rf_wr_o  out  1  register-file write strobe (registered)
- rf_addr_o  out  5  register-file write address (registered)
- rf_data_o  out  C_XLEN  register-file write data (registered)
- ids_rs1_addr_i, ids_rs2_addr_i, ids_rd_addr_i  in  5 each  operands of the instruction being decoded
- ids_hazard_o  out  1  decoded instruction touches a register with a pending load
- ids_stall_o  out  1  decoder must not issue (load-return starvation)

## Operation
- Grant (combinational, only when clk_en_i=1):
  - EX has absolute priority.
  - lq_ack_o = clk_en_i & lq_dav_i & ~ex_regd_wr_i.
- Write port register (updates on enabled edge):
  - rf_wr_o <= 1 when EX or LQ is granted and the granted address ≠ 0; otherwise 0.
  - rf_addr_o/rf_data_o <= the granted source's address and data; they hold when there is no grant.
  - A src_lq_q flag records that the registered write came from LQ.
  - An LQ return to x0 is still acknowledged but produces no write.
- Scoreboard: 32-bit pend_q; bit 0 is hard-wired 0.
  - Set: ex_lq_wr_i sets bit ex_lq_regd_addr_i.
  - Clear: rf_wr_o & src_lq_q clears bit rf_addr_o at the next enabled edge, so a hazard drops only once the register file holds the data.
  - Set and clear on the same address in the same cycle: set wins.
- Hazard (combinational): ids_hazard_o = 1 if any nonzero rs1/rs2/rd matches a set pend_q bit, or matches ex_lq_regd_addr_i while ex_lq_wr_i=1. The rd check blocks WAW, so a second load to a pending register never issues.
- Starvation counter: 4-bit starve_q.
  - Increments (saturating at C_STARVE_MAX) each enabled cycle with lq_dav_i=1 and lq_ack_o=0.
  - Clears on lq_ack_o=1 or when lq_dav_i=0.
- Stall: stall_q.
  - Set when starve_q reaches C_STARVE_MAX.
  - Cleared on the edge where LQ is acknowledged.
  - ids_stall_o = stall_q.

## Timing
- Reset values: rf_wr_o=0, rf_addr_o=0, rf_data_o=0, src_lq_q=0, pend_q=0, starve_q=0, stall_q=0, ids_stall_o=0, lq_ack_o=0, ids_hazard_o=0.
- Reset asserted mid-operation: all of the above are cleared immediately; pending loads are forgotten. The LSQ is reset by the same signal.
- Grant to rf_wr_o: 1 cycle. Scoreboard set to visible in pend_q: 1 cycle; the ex_lq_wr_i bypass covers that cycle.
- Stall latency:
  - ids_stall_o rises on the edge after the C_STARVE_MAX-th unacknowledged cycle.
  - EX is drained by the stage register within 1 cycle, so LQ is granted no later than 2 cycles after the stall rises.
  - ids_stall_o falls on the grant edge.
- clk_en_i=0: there are no grants and no state changes. Outputs hold, and lq_ack_o=0.

## Test plan
- EX write r5=0x1234 and LQ return r6 in the same cycle -> rf writes r5 on the next cycle, lq_ack_o=0. LQ r6 is written the cycle after EX goes idle.
- ex_lq_wr_i to r7, then ids_rs1=r7 -> ids_hazard_o=1 in the issue cycle (bypass) and onward. It stays 1 until the cycle after rf_wr_o writes r7 from LQ, then 0.
- Continuous EX writes with lq_dav_i held, C_STARVE_MAX=4 -> ids_stall_o=1 after 4 cycles. LQ is acknowledged once EX drops, and ids_stall_o=0 on the next cycle.
- LQ return to x0 -> lq_ack_o=1, rf_wr_o stays 0, pend_q unchanged. EX write to x0 -> no write.
- Load issued to r9 while the pending r9 load completes in the same cycle -> pend_q[9] remains 1.
- Assert resetb_i low while pend_q≠0 and stall_q=1 -> all outputs and state return to their reset values immediately. With clk_en_i=0 and lq_dav_i=1 -> lq_ack_o=0 and starve_q is frozen.

Source files
------------

// File: rtl/regd_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regd_wb_arbiter
//
// Shares the single register-file write port between the execute stage's
// direct writeback and load-queue return data. Tracks which registers still
// wait on an outstanding load, reports RAW/WAW hazards to the decoder, and
// stalls the decoder when load returns have been starved too long.
//
// Ports
//   clk_i, resetb_i        clock, asynchronous active-low reset
//   clk_en_i               global enable; low freezes all state and grants
//   ex_regd_*_i            EX writeback request (never back-pressured)
//   ex_lq_wr_i,
//   ex_lq_regd_addr_i      load pushed to the load queue and its destination
//   lq_dav_i, lq_regd_*_i  load return request, destination and data
//   lq_ack_o               load return accepted this cycle
//   rf_wr_o/addr_o/data_o  registered register-file write port
//   ids_rs1/rs2/rd_addr_i  operands of the instruction being decoded
//   ids_hazard_o           decoded instruction touches a pending-load register
//   ids_stall_o            decoder must not issue (load-return starvation)
// ---------------------------------------------------------------------------
module regd_wb_arbiter #(
  parameter int C_XLEN       = 32,
  parameter int C_STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  input  logic              ex_regd_wr_i,
  input  logic [4:0]        ex_regd_addr_i,
  input  logic [C_XLEN-1:0] ex_regd_data_i,
  input  logic              ex_lq_wr_i,
  input  logic [4:0]        ex_lq_regd_addr_i,
  input  logic              lq_dav_i,
  output logic              lq_ack_o,
  input  logic [4:0]        lq_regd_addr_i,
  input  logic [C_XLEN-1:0] lq_regd_data_i,
  output logic              rf_wr_o,
  output logic [4:0]        rf_addr_o,
  output logic [C_XLEN-1:0] rf_data_o,
  input  logic [4:0]        ids_rs1_addr_i,
  input  logic [4:0]        ids_rs2_addr_i,
  input  logic [4:0]        ids_rd_addr_i,
  output logic              ids_hazard_o,
  output logic              ids_stall_o
);

  localparam logic [3:0] LP_STARVE_MAX = 4'(C_STARVE_MAX);

  // -------------------------------------------------------------------------
  // Grant: EX always wins, LQ only gets the port when EX is idle.
  // -------------------------------------------------------------------------
  logic              w_ex_gnt;
  logic              w_lq_gnt;
  logic              w_any_gnt;
  logic [4:0]        w_gnt_addr;
  logic [C_XLEN-1:0] w_gnt_data;

  assign w_ex_gnt   = clk_en_i & ex_regd_wr_i;
  assign w_lq_gnt   = clk_en_i & lq_dav_i & ~ex_regd_wr_i;
  assign w_any_gnt  = w_ex_gnt | w_lq_gnt;
  assign w_gnt_addr = w_ex_gnt ? ex_regd_addr_i : lq_regd_addr_i;
  assign w_gnt_data = w_ex_gnt ? ex_regd_data_i : lq_regd_data_i;

  // Held at 0 while reset is asserted so the LSQ never sees an accept for a
  // return that the (resetting) write port would drop.
  assign lq_ack_o = resetb_i & w_lq_gnt;

  // -------------------------------------------------------------------------
  // Registered write port. Address/data hold without a grant; a grant to x0
  // still loads them but never raises the strobe.
  // -------------------------------------------------------------------------
  logic              r_rf_wr;
  logic [4:0]        r_rf_addr;
  logic [C_XLEN-1:0] r_rf_data;
  logic              r_src_lq;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; combinational blocks below use blocking (=).
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_rf_wr   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
      r_src_lq  <= 1'b0;
    end else if (clk_en_i) begin
      r_rf_wr  <= w_any_gnt & (w_gnt_addr != 5'd0);
      r_src_lq <= w_lq_gnt;
      if (w_any_gnt) begin
        r_rf_addr <= w_gnt_addr;
        r_rf_data <= w_gnt_data;
      end
    end
  end

  assign rf_wr_o   = r_rf_wr;
  assign rf_addr_o = r_rf_addr;
  assign rf_data_o = r_rf_data;

  // -------------------------------------------------------------------------
  // Pending-load scoreboard. A bit clears only after the LQ data has actually
  // been written (registered strobe), so the hazard cannot drop early. A new
  // load to the same register in that cycle re-sets the bit (set wins).
  // -------------------------------------------------------------------------
  logic [31:0] r_pend;
  logic [31:0] w_pend_nxt;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_pend_nxt = r_pend;
    if (r_rf_wr && r_src_lq) w_pend_nxt[r_rf_addr] = 1'b0;
    if (ex_lq_wr_i)          w_pend_nxt[ex_lq_regd_addr_i] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  // NOTE: the scoreboard is a flop vector, not a RAM, and must be reset:
  // the LSQ is cleared by the same reset, so pending loads are forgotten.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i)     r_pend <= '0;
    else if (clk_en_i) r_pend <= w_pend_nxt;
  end

  // -------------------------------------------------------------------------
  // Hazard: a nonzero operand hits a pending bit, or the load being pushed
  // this very cycle (bypass for the one cycle before pend shows it).
  // -------------------------------------------------------------------------
  function automatic logic f_hit(input logic [4:0]  a,
                                 input logic [31:0] pend,
                                 input logic        byp_vld,
                                 input logic [4:0]  byp_addr);
    return (a != 5'd0) && (pend[a] || (byp_vld && (byp_addr == a)));
  endfunction

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_rd_hit;

  assign w_rs1_hit = f_hit(ids_rs1_addr_i, r_pend, ex_lq_wr_i, ex_lq_regd_addr_i);
  assign w_rs2_hit = f_hit(ids_rs2_addr_i, r_pend, ex_lq_wr_i, ex_lq_regd_addr_i);
  assign w_rd_hit  = f_hit(ids_rd_addr_i,  r_pend, ex_lq_wr_i, ex_lq_regd_addr_i);

  assign ids_hazard_o = resetb_i & (w_rs1_hit | w_rs2_hit | w_rd_hit);

  // -------------------------------------------------------------------------
  // Starvation: count consecutive enabled cycles with an unaccepted return.
  // The stall rises on the same edge the count reaches its limit and falls
  // on the edge that accepts the return.
  // -------------------------------------------------------------------------
  logic [3:0] r_starve;
  logic [3:0] w_starve_nxt;
  logic       r_stall;

  always_comb begin
    w_starve_nxt = 4'd0;
    if (lq_dav_i && !w_lq_gnt) begin
      w_starve_nxt = (r_starve >= LP_STARVE_MAX) ? LP_STARVE_MAX
                                                 : r_starve + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_starve <= 4'd0;
      r_stall  <= 1'b0;
    end else if (clk_en_i) begin
      r_starve <= w_starve_nxt;
      if (w_lq_gnt)                            r_stall <= 1'b0;
      else if (w_starve_nxt == LP_STARVE_MAX) r_stall <= 1'b1;
    end
  end

  assign ids_stall_o = r_stall;

endmodule

// File: tb/tb_regd_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regd_wb_arbiter
//
// Directed bench for regd_wb_arbiter (C_XLEN=32, C_STARVE_MAX=4). Each table
// record drives one cycle: combinational outputs (lq_ack_o, ids_hazard_o)
// are compared mid-cycle, registered outputs 1 time unit after the edge.
// A hand-written sequence covers reset asserted mid-operation.
// ---------------------------------------------------------------------------
module tb_regd_wb_arbiter;

  logic        clk;
  logic        resetb;
  logic        clk_en;
  logic        ex_wr;
  logic [4:0]  ex_addr;
  logic [31:0] ex_data;
  logic        ex_lq_wr;
  logic [4:0]  ex_lq_addr;
  logic        lq_dav;
  logic        lq_ack;
  logic [4:0]  lq_addr;
  logic [31:0] lq_data;
  logic        rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [4:0]  rs1, rs2, rd;
  logic        hazard;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  regd_wb_arbiter #(.C_XLEN(32), .C_STARVE_MAX(4)) dut (
    .clk_i             (clk),
    .resetb_i          (resetb),
    .clk_en_i          (clk_en),
    .ex_regd_wr_i      (ex_wr),
    .ex_regd_addr_i    (ex_addr),
    .ex_regd_data_i    (ex_data),
    .ex_lq_wr_i        (ex_lq_wr),
    .ex_lq_regd_addr_i (ex_lq_addr),
    .lq_dav_i          (lq_dav),
    .lq_ack_o          (lq_ack),
    .lq_regd_addr_i    (lq_addr),
    .lq_regd_data_i    (lq_data),
    .rf_wr_o           (rf_wr),
    .rf_addr_o         (rf_addr),
    .rf_data_o         (rf_data),
    .ids_rs1_addr_i    (rs1),
    .ids_rs2_addr_i    (rs2),
    .ids_rd_addr_i     (rd),
    .ids_hazard_o      (hazard),
    .ids_stall_o       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        ex_wr;
    logic [4:0]  ex_addr;
    logic [31:0] ex_data;
    logic        lqw;
    logic [4:0]  lqw_addr;
    logic        dav;
    logic [4:0]  lq_addr;
    logic [31:0] lq_data;
    logic [4:0]  rs1, rs2, rd;
    logic        e_ack;
    logic        e_haz;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic v(input int en, input int exw, input int exa, input int exd,
                   input int lqw, input int lqwa, input int dav, input int lqa,
                   input int lqd, input int r1, input int r2, input int rdd,
                   input int ack, input int haz, input int wr, input int addr,
                   input int data, input int stl);
    vec_t t;
    t.en = 1'(en);   t.ex_wr = 1'(exw); t.ex_addr = 5'(exa); t.ex_data = 32'(exd);
    t.lqw = 1'(lqw); t.lqw_addr = 5'(lqwa);
    t.dav = 1'(dav); t.lq_addr = 5'(lqa); t.lq_data = 32'(lqd);
    t.rs1 = 5'(r1);  t.rs2 = 5'(r2); t.rd = 5'(rdd);
    t.e_ack = 1'(ack); t.e_haz = 1'(haz); t.e_wr = 1'(wr);
    t.e_addr = 5'(addr); t.e_data = 32'(data); t.e_stall = 1'(stl);
    vecs.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    clk_en     = t.en;
    ex_wr      = t.ex_wr;    ex_addr = t.ex_addr; ex_data = t.ex_data;
    ex_lq_wr   = t.lqw;      ex_lq_addr = t.lqw_addr;
    lq_dav     = t.dav;      lq_addr = t.lq_addr; lq_data = t.lq_data;
    rs1 = t.rs1; rs2 = t.rs2; rd = t.rd;
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    drive(t);
    #1;
    check($sformatf("v%0d_ack", idx), {31'd0, lq_ack}, {31'd0, t.e_ack});
    check($sformatf("v%0d_hazard", idx), {31'd0, hazard}, {31'd0, t.e_haz});
    @(posedge clk);
    #1;
    check($sformatf("v%0d_rf_wr", idx), {31'd0, rf_wr}, {31'd0, t.e_wr});
    check($sformatf("v%0d_rf_addr", idx), {27'd0, rf_addr}, {27'd0, t.e_addr});
    check($sformatf("v%0d_rf_data", idx), rf_data, t.e_data);
    check($sformatf("v%0d_stall", idx), {31'd0, stall}, {31'd0, t.e_stall});
  endtask

  task automatic idle_inputs();
    clk_en = 1'b1; ex_wr = 1'b0; ex_addr = '0; ex_data = '0;
    ex_lq_wr = 1'b0; ex_lq_addr = '0; lq_dav = 1'b0; lq_addr = '0; lq_data = '0;
    rs1 = '0; rs2 = '0; rd = '0;
  endtask

  initial begin
    // Columns: en exw exa exd | lqw lqwa | dav lqa lqd | rs1 rs2 rd ||
    //          ack haz | rf_wr rf_addr rf_data stall
    // EX vs LQ in the same cycle, then LQ after EX goes idle.
    v(1,1,5,'h1234, 0,0, 1,6,'hAAAA, 0,0,0,  0,0, 1,5,'h1234,0);
    v(1,0,0,0,      0,0, 1,6,'hAAAA, 0,0,0,  1,0, 1,6,'hAAAA,0);
    // RAW via bypass, held until the cycle after the LQ write of r7.
    v(1,0,0,0,      1,7, 0,0,0,      7,0,0,  0,1, 0,6,'hAAAA,0);
    v(1,0,0,0,      0,0, 0,0,0,      7,0,0,  0,1, 0,6,'hAAAA,0);
    v(1,0,0,0,      0,0, 1,7,'h77,   7,0,0,  1,1, 1,7,'h77,0);
    v(1,0,0,0,      0,0, 0,0,0,      7,0,0,  0,1, 0,7,'h77,0);
    v(1,0,0,0,      0,0, 0,0,0,      7,0,0,  0,0, 0,7,'h77,0);
    // x0: load to x0 never flagged; LQ and EX returns to x0 never write.
    v(1,0,0,0,      1,0, 0,0,0,      0,0,0,  0,0, 0,7,'h77,0);
    v(1,0,0,0,      0,0, 1,0,'h55,   0,0,0,  1,0, 0,0,'h55,0);
    v(1,1,0,'h99,   0,0, 0,0,0,      0,0,0,  0,0, 0,0,'h99,0);
    // WAW on rd; re-issue to r9 while pending r9 completes: set wins.
    v(1,0,0,0,      1,9, 0,0,0,      0,0,9,  0,1, 0,0,'h99,0);
    v(1,0,0,0,      0,0, 1,9,'h999,  3,0,9,  1,1, 1,9,'h999,0);
    v(1,0,0,0,      1,9, 0,0,0,      0,0,9,  0,1, 0,9,'h999,0);
    v(1,0,0,0,      0,0, 0,0,0,      9,0,0,  0,1, 0,9,'h999,0);
    v(1,0,0,0,      0,0, 1,9,'h1,    0,9,0,  1,1, 1,9,'h1,0);
    v(1,0,0,0,      0,0, 0,0,0,      0,9,0,  0,1, 0,9,'h1,0);
    v(1,0,0,0,      0,0, 0,0,0,      3,9,0,  0,0, 0,9,'h1,0);
    // Starvation: 4 unacknowledged cycles raise stall; saturates; ack drops it.
    v(1,1,1,'h1,    0,0, 1,12,'hC,   0,0,0,  0,0, 1,1,'h1,0);
    v(1,1,2,'h2,    0,0, 1,12,'hC,   0,0,0,  0,0, 1,2,'h2,0);
    v(1,1,3,'h3,    0,0, 1,12,'hC,   0,0,0,  0,0, 1,3,'h3,0);
    v(1,1,4,'h4,    0,0, 1,12,'hC,   0,0,0,  0,0, 1,4,'h4,1);
    v(1,1,5,'h5,    0,0, 1,12,'hC,   0,0,0,  0,0, 1,5,'h5,1);
    v(1,0,0,0,      0,0, 1,12,'hC,   0,0,0,  1,0, 1,12,'hC,0);
    // Clock enable low: no ack, outputs hold.
    v(0,1,3,'h3,    0,0, 1,12,'hC,   0,0,0,  0,0, 1,12,'hC,0);
    // Starve count frozen across disabled cycles (2 + 0 + 2 -> stall on 4th).
    v(1,1,2,'h22,   0,0, 1,12,'hC,   0,0,0,  0,0, 1,2,'h22,0);
    v(1,1,3,'h33,   0,0, 1,12,'hC,   0,0,0,  0,0, 1,3,'h33,0);
    v(0,1,4,'h44,   1,15,1,12,'hC,  15,0,0,  0,1, 1,3,'h33,0);
    v(0,1,4,'h44,   0,0, 1,12,'hC,  15,0,0,  0,0, 1,3,'h33,0);
    v(0,1,4,'h44,   0,0, 1,12,'hC,   0,0,0,  0,0, 1,3,'h33,0);
    v(1,1,4,'h44,   0,0, 1,12,'hC,   0,0,0,  0,0, 1,4,'h44,0);
    v(1,1,5,'h55,   0,0, 1,12,'hC,   0,0,0,  0,0, 1,5,'h55,1);
    v(1,0,0,0,      0,0, 1,12,'hC,   0,0,0,  1,0, 1,12,'hC,0);
    // lq_dav dropping clears the count (3, clear, then 4 more needed).
    v(1,1,1,'h11,   0,0, 1,12,'hC,   0,0,0,  0,0, 1,1,'h11,0);
    v(1,1,2,'h22,   0,0, 1,12,'hC,   0,0,0,  0,0, 1,2,'h22,0);
    v(1,1,3,'h33,   0,0, 1,12,'hC,   0,0,0,  0,0, 1,3,'h33,0);
    v(1,1,4,'h44,   0,0, 0,12,'hC,   0,0,0,  0,0, 1,4,'h44,0);
    v(1,1,5,'h55,   0,0, 1,12,'hC,   0,0,0,  0,0, 1,5,'h55,0);
    v(1,1,6,'h66,   0,0, 1,12,'hC,   0,0,0,  0,0, 1,6,'h66,0);
    v(1,1,7,'h77,   0,0, 1,12,'hC,   0,0,0,  0,0, 1,7,'h77,0);
    v(1,1,8,'h88,   0,0, 1,12,'hC,   0,0,0,  0,0, 1,8,'h88,1);
    v(1,0,0,0,      0,0, 1,12,'hC,   0,0,0,  1,0, 1,12,'hC,0);

    // ---------------- Reset state (inputs that would otherwise grant/flag).
    idle_inputs();
    resetb = 1'b0;
    lq_dav = 1'b1; ex_lq_wr = 1'b1; ex_lq_addr = 5'd3; rs1 = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack",     {31'd0, lq_ack}, 32'd0);
    check("rst_hazard",  {31'd0, hazard}, 32'd0);
    check("rst_rf_wr",   {31'd0, rf_wr},  32'd0);
    check("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    check("rst_rf_data", rf_data, 32'd0);
    check("rst_stall",   {31'd0, stall},  32'd0);
    @(negedge clk);
    idle_inputs();
    rs1 = 5'd3;
    resetb = 1'b1;
    #1;
    check("rst_no_pend_r3", {31'd0, hazard}, 32'd0);

    // ---------------- Table.
    foreach (vecs[i]) apply(vecs[i], i);

    // ---------------- Reset mid-operation: pend r20 set and stall=1.
    @(negedge clk);
    idle_inputs();
    ex_lq_wr = 1'b1; ex_lq_addr = 5'd20;
    @(posedge clk);
    @(negedge clk);
    ex_lq_wr = 1'b0;
    lq_dav = 1'b1; lq_addr = 5'd12; lq_data = 32'hC;
    for (int i = 0; i < 4; i++) begin
      ex_wr = 1'b1; ex_addr = 5'(i + 1); ex_data = 32'(i + 'h100);
      @(negedge clk);
    end
    ex_wr = 1'b0; rs1 = 5'd20;
    #1;
    check("mid_pre_stall",  {31'd0, stall},  32'd1);
    check("mid_pre_hazard", {31'd0, hazard}, 32'd1);
    check("mid_pre_ack",    {31'd0, lq_ack}, 32'd1);
    #1;
    resetb = 1'b0;
    #1;
    check("mid_rst_ack",     {31'd0, lq_ack}, 32'd0);
    check("mid_rst_hazard",  {31'd0, hazard}, 32'd0);
    check("mid_rst_rf_wr",   {31'd0, rf_wr},  32'd0);
    check("mid_rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    check("mid_rst_rf_data", rf_data, 32'd0);
    check("mid_rst_stall",   {31'd0, stall},  32'd0);
    @(negedge clk);
    resetb = 1'b1;
    #1;
    check("mid_post_hazard", {31'd0, hazard}, 32'd0);
    check("mid_post_ack",    {31'd0, lq_ack}, 32'd1);
    @(posedge clk);
    #1;
    check("mid_post_rf_wr",   {31'd0, rf_wr},  32'd1);
    check("mid_post_rf_addr", {27'd0, rf_addr}, 32'd12);
    check("mid_post_stall",   {31'd0, stall},  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
